// File: rtl/plic_apb_mtx.sv
// APB bus matrix in front of the PLIC register slaves: one host transfer at a time, decoded to one of four slaves.
// Optional access timeout is built only when PLIC_APB_TIMEOUT_EN is defined.
module plic_apb_mtx #(
   parameter int                ADDR_W  = 27,
   parameter int                TMO_W   = 8,
   parameter logic [TMO_W-1:0]  TMO_CYC = 8'd255
) (
   input  logic               plic_clk,
   input  logic               plicrst,
   input  logic               ciu_plic_psel,
   input  logic               ciu_plic_penable,
   input  logic               ciu_plic_pwrite,
   input  logic               ciu_plic_psec,
   input  logic [ADDR_W-1:0]  ciu_plic_paddr,
   input  logic [1:0]         ciu_plic_pprot,
   input  logic [31:0]        ciu_plic_pwdata,
   output logic [31:0]        plic_ciu_prdata,
   output logic               plic_ciu_pready,
   output logic               plic_ciu_pslverr,
   output logic [3:0]         bus_mtx_plic_psel,
   output logic               bus_mtx_plic_penable,
   output logic               bus_mtx_plic_pwrite,
   output logic               bus_mtx_plic_psec,
   output logic [ADDR_W-1:0]  bus_mtx_plic_paddr,
   output logic [1:0]         bus_mtx_plic_pprot,
   output logic [31:0]        bus_mtx_plic_pwdata,
   input  logic [127:0]       slv_prdata,
   input  logic [3:0]         slv_pready,
   input  logic [3:0]         slv_pslverr
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                write_q, write_d;
   logic [1:0]          prot_q, prot_d;
   logic                sec_q, sec_d;
   logic [1:0]          sel_q, sel_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                err_q, err_d;
`ifdef PLIC_APB_TIMEOUT_EN
   logic [TMO_W-1:0]    cnt_q, cnt_d;
`endif

   logic                req_map;
   logic [1:0]          req_sel;
   logic                active;
   logic                resp;

   function automatic logic [2:0] decode(input logic [ADDR_W-1:0] a);
      logic [31:0] a32;
      a32 = 32'(a);
      if (a32 <= 32'h0000FFF)      decode = 3'b100;
      else if (a32 <= 32'h0001FFF) decode = 3'b101;
      else if (a32 <= 32'h1FFEFFF) decode = 3'b110;
      else if (a32 <= 32'h1FFFFFF) decode = 3'b111;
      else                         decode = 3'b000;
   endfunction

   assign {req_map, req_sel} = decode(ciu_plic_paddr);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      write_d = write_q;
      prot_d  = prot_q;
      sec_d   = sec_q;
      sel_d   = sel_q;
      rdata_d = rdata_q;
      err_d   = err_q;
`ifdef PLIC_APB_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (ciu_plic_psel && !ciu_plic_penable) begin
               addr_d  = ciu_plic_paddr;
               wdata_d = ciu_plic_pwdata;
               write_d = ciu_plic_pwrite;
               prot_d  = ciu_plic_pprot;
               sec_d   = ciu_plic_psec;
               sel_d   = req_sel;
               if (req_map) begin
                  state_d = SETUP;
               end else begin
                  state_d = RESP;
                  rdata_d = '0;
                  err_d   = 1'b1;
               end
            end
         end
         SETUP: begin
            state_d = ACCESS;
`ifdef PLIC_APB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         ACCESS: begin
            if (slv_pready[sel_q]) begin
               // Write responses carry no data back to the host.
               rdata_d = write_q ? 32'h0 : slv_prdata[{sel_q, 5'b0} +: 32];
               err_d   = slv_pslverr[sel_q];
               state_d = RESP;
            end
`ifdef PLIC_APB_TIMEOUT_EN
            else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == TMO_CYC) begin
                  rdata_d = '0;
                  err_d   = 1'b1;
                  state_d = RESP;
               end
            end
`endif
         end
         RESP: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge plic_clk or posedge plicrst) begin
      if (plicrst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         prot_q  <= '0;
         sec_q   <= 1'b0;
         sel_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
`ifdef PLIC_APB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
         prot_q  <= prot_d;
         sec_q   <= sec_d;
         sel_q   <= sel_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
`ifdef PLIC_APB_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // Outputs are gated by the state register so an async reset clears them immediately.
   assign active = (state_q == SETUP) || (state_q == ACCESS);
   assign resp   = (state_q == RESP);

   assign bus_mtx_plic_psel    = active ? (4'b0001 << sel_q) : 4'b0000;
   assign bus_mtx_plic_penable = (state_q == ACCESS);
   assign bus_mtx_plic_pwrite  = active & write_q;
   assign bus_mtx_plic_psec    = active & sec_q;
   assign bus_mtx_plic_paddr   = active ? addr_q : '0;
   assign bus_mtx_plic_pprot   = active ? prot_q : 2'b00;
   assign bus_mtx_plic_pwdata  = active ? wdata_q : 32'h0;

   assign plic_ciu_pready  = resp;
   assign plic_ciu_pslverr = resp & err_q;
   assign plic_ciu_prdata  = resp ? rdata_q : 32'h0;

endmodule
